// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the player-button front end.
//   BTN_UP..BTN_B : channel index of each named button in the raw key vector
//   btn_state_t   : per-channel debounce state encoding (2 bits)
//   cnt_width     : counter width for a given largest count (minimum 1 bit)
package button_conditioner_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_START = 4;
  localparam int unsigned BTN_A     = 5;
  localparam int unsigned BTN_B     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRS_CHK = 2'd1,
    HELD    = 2'd2,
    REL_CHK = 2'd3
  } btn_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Build option: AUTO_REPEAT_EN adds the repeat counter and REPEAT_* parameters.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_raw      : asynchronous raw key
//   o_pulse    : registered one-cycle press pulse
//   o_held     : registered debounced level, 1 = pressed
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 7500000,
  parameter bit          REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_held
);

  localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W    = cnt_width(REP_MAX);
  localparam logic [REP_W-1:0] DEL_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rcnt, w_rcnt_next;
  logic             r_rep, w_rep_next;
`endif

  logic             r_sync1, r_sync2;
  logic             w_s;
  btn_state_t       r_state, w_state_next;
  logic [DB_W-1:0]  r_cnt, w_cnt_next;
  logic             r_pulse, w_pulse_next;
  logic             r_held, w_held_next;

  // Synchroniser resets to the released raw level so reset never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW;

  // State and output registers; reset lands in REL_CHK to lock out keys held through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= REL_CHK;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rcnt  <= '0;
      r_rep   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      r_held  <= w_held_next;
`ifdef AUTO_REPEAT_EN
      r_rcnt  <= w_rcnt_next;
      r_rep   <= w_rep_next;
`endif
    end
  end

  // Debounce next-state; held only rises on an accepted press, so a locked-out key stays silent
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pulse_next = 1'b0;
    w_held_next  = r_held;
`ifdef AUTO_REPEAT_EN
    w_rcnt_next  = r_rcnt;
    w_rep_next   = r_rep;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_next = PRS_CHK;
          w_cnt_next   = '0;
        end
      end
      PRS_CHK: begin
        if (!w_s) begin
          w_state_next = IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = HELD;
          w_pulse_next = 1'b1;
          w_held_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_next = REL_CHK;
          w_cnt_next   = '0;
        end
`ifdef AUTO_REPEAT_EN
        // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD
        else if (REPEAT_EN && r_held) begin
          if (r_rcnt == (r_rep ? PER_LAST : DEL_LAST)) begin
            w_pulse_next = 1'b1;
            w_rcnt_next  = '0;
            w_rep_next   = 1'b1;
          end else begin
            w_rcnt_next = r_rcnt + 1'b1;
          end
        end
`endif
      end
      REL_CHK: begin
        if (w_s) begin
          w_state_next = HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = IDLE;
          w_held_next  = 1'b0;
`ifdef AUTO_REPEAT_EN
          w_rcnt_next  = '0;
          w_rep_next   = 1'b0;
`endif
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule

// File: rtl/button_conditioner.sv
// Player-button front end: synchronises, debounces and edge-detects the raw board keys
// and maps each channel's press pulse to the named game-FSM inputs.
// Build option: AUTO_REPEAT_EN enables auto-repeat on channels selected by REPEAT_MASK.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   i_raw_keys       : raw keys, bit 0 up, 1 down, 2 left, 3 right, 4 start, 5 a, 6 b
//   o_up_button..o_b_button : registered one-cycle press pulses per channel
//   o_held           : registered debounced level per channel, 1 = pressed
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 7,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 7500000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = NUM_BUTTONS'(7'h0F)
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] i_raw_keys,
  output logic                   o_up_button,
  output logic                   o_down_button,
  output logic                   o_left_button,
  output logic                   o_right_button,
  output logic                   o_start_button,
  output logic                   o_a_button,
  output logic                   o_b_button,
  output logic [NUM_BUTTONS-1:0] o_held
);

  logic [NUM_BUTTONS-1:0] w_pulse;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[g])
`endif
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (i_raw_keys[g]),
      .o_pulse (w_pulse[g]),
      .o_held  (o_held[g])
    );
  end

  assign o_up_button    = w_pulse[BTN_UP];
  assign o_down_button  = w_pulse[BTN_DOWN];
  assign o_left_button  = w_pulse[BTN_LEFT];
  assign o_right_button = w_pulse[BTN_RIGHT];
  assign o_start_button = w_pulse[BTN_START];
  assign o_a_button     = w_pulse[BTN_A];
  assign o_b_button     = w_pulse[BTN_B];

endmodule
